dffrf_bist: RTL and testbench

March-test engine that is the initiator side of the 2R1W flop/latch register-file port. It drives RA/RB/RW/WE/DW and checks DA/DB on both read ports. It runs a fixed six-element March C- sequence on demand and reports pass/fail with the first failing address. It sits between the Caravel-side control registers (START/status) and one DFFRF_2R1W instance, muxed ahead of the functional port by the integrator.

---
 rtl/dffrf_bist_pkg.sv | 52 +++++
 rtl/dffrf_bist_cmp.sv | 92 +++++++++
 rtl/dffrf_bist.sv | 131 +++++++++++++
 tb/tb_dffrf_bist.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dffrf_bist_pkg.sv
// Shared types and the March C- element table for the register-file BIST engine.
package dffrf_bist_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_M0    = 4'd1,
    S_M1    = 4'd2,
    S_M2    = 4'd3,
    S_M3    = 4'd4,
    S_M4    = 4'd5,
    S_M5    = 4'd6,
    S_DRAIN = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  localparam int ELEM_CNT = 6;
  localparam int ELEM_W   = 3;

  typedef struct packed {
    logic down;
    logic rd;
    logic rd_inv;
    logic wr;
    logic wr_inv;
  } march_row_t;

  // {down, rd, rd_inv, wr, wr_inv}; *_inv selects ~P instead of P
  localparam march_row_t MARCH_TBL [ELEM_CNT] = '{
    5'b00010,
    5'b01011,
    5'b01110,
    5'b11011,
    5'b11110,
    5'b11000
  };

  function automatic logic is_march(input state_t s);
    return (s >= S_M0) && (s <= S_M5);
  endfunction

  function automatic logic [ELEM_W-1:0] elem_of(input state_t s);
    logic [3:0] d;
    d = 4'(s) - 4'd1;
    return d[ELEM_W-1:0];
  endfunction

  function automatic march_row_t march_row(input state_t s);
    if (!is_march(s)) return '0;
    return MARCH_TBL[elem_of(s)];
  endfunction

endpackage

// File: rtl/dffrf_bist_cmp.sv
// Read-latency-matched compare pipeline with first-failure capture.
module dffrf_bist_cmp
  import dffrf_bist_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clr,
  input  logic              vld_p0,
  input  logic [DATA_W-1:0] exp_p0,
  input  logic [ADDR_W-1:0] addr_p0,
  input  logic [ELEM_W-1:0] elem_p0,
  input  logic [DATA_W-1:0] DA,
  input  logic [DATA_W-1:0] DB,
  output logic              FAIL,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [ELEM_W-1:0] FAIL_ELEM,
  output logic [1:0]        FAIL_PORT
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ELEM_W-1:0] elem_q;
  logic              miss_a;
  logic              miss_b;

  if (RD_LAT == 0) begin : g_comb
    assign vld_q  = vld_p0;
    assign exp_q  = exp_p0;
    assign addr_q = addr_p0;
    assign elem_q = elem_p0;
  end else begin : g_pipe
    logic              vld_p  [1:RD_LAT];
    logic [DATA_W-1:0] exp_p  [1:RD_LAT];
    logic [ADDR_W-1:0] addr_p [1:RD_LAT];
    logic [ELEM_W-1:0] elem_p [1:RD_LAT];

    // Stage 0 -> RD_LAT: tag travels with the RF read data
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int i = 1; i <= RD_LAT; i++) vld_p[i] <= 1'b0;
      end else begin
        vld_p[1] <= vld_p0;
        for (int i = 2; i <= RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    always_ff @(posedge CLK) begin
      exp_p[1]  <= exp_p0;
      addr_p[1] <= addr_p0;
      elem_p[1] <= elem_p0;
      for (int i = 2; i <= RD_LAT; i++) begin
        exp_p[i]  <= exp_p[i-1];
        addr_p[i] <= addr_p[i-1];
        elem_p[i] <= elem_p[i-1];
      end
    end

    assign vld_q  = vld_p[RD_LAT];
    assign exp_q  = exp_p[RD_LAT];
    assign addr_q = addr_p[RD_LAT];
    assign elem_q = elem_p[RD_LAT];
  end

  assign miss_a = vld_q && (DA != exp_q);
  assign miss_b = vld_q && (DB != exp_q);

  // Compare stage: only the first mismatch of a run is recorded
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= '0;
      FAIL_PORT <= '0;
    end else if (clr) begin
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= '0;
      FAIL_PORT <= '0;
    end else if ((miss_a || miss_b) && !FAIL) begin
      FAIL      <= 1'b1;
      FAIL_ADDR <= addr_q;
      FAIL_ELEM <= elem_q;
      FAIL_PORT <= {miss_b, miss_a};
    end
  end

endmodule

// File: rtl/dffrf_bist.sv
// March C- BIST initiator for a 2R1W register file; drives both read ports and the write port.
module dffrf_bist
  import dffrf_bist_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [2:0]        FAIL_ELEM,
  output logic [1:0]        FAIL_PORT,
  output logic [ADDR_W-1:0] RA,
  output logic [ADDR_W-1:0] RB,
  input  logic [DATA_W-1:0] DA,
  input  logic [DATA_W-1:0] DB,
  output logic              WE,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] DW
);

  function automatic logic [DATA_W-1:0] alt_pat();
    logic [DATA_W-1:0] p;
    for (int i = 0; i < DATA_W; i++) p[i] = ((i % 2) == 0);
    return p;
  endfunction

  localparam logic [DATA_W-1:0] PAT      = alt_pat();
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [1:0]        drain_cnt, drain_nx;
  logic              start_acc;
  logic              last_addr;
  march_row_t        row, row_nx;
  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ELEM_W-1:0] cmp_elem;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      addr      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      drain_cnt <= drain_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    addr_nx   = addr;
    drain_nx  = drain_cnt;
    start_acc = 1'b0;
    row       = march_row(state);
    row_nx    = '0;
    last_addr = row.down ? (addr == '0) : (addr == ADDR_MAX);
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_nx  = S_M0;
          addr_nx   = '0;
          start_acc = 1'b1;
        end
      end
      S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
        if (!last_addr) begin
          addr_nx = row.down ? addr - 1'b1 : addr + 1'b1;
        end else if (state == S_M5) begin
          state_nx = S_DRAIN;
          addr_nx  = '0;
          drain_nx = '0;
        end else begin
          state_nx = state_t'(4'(state) + 4'd1);
          row_nx   = march_row(state_nx);
          addr_nx  = row_nx.down ? ADDR_MAX : '0;
        end
      end
      S_DRAIN: begin
        // DRAIN spans RD_LAT+1 cycles so the last registered read is compared
        if (drain_cnt == 2'(RD_LAT)) state_nx = S_DONE;
        else                         drain_nx = drain_cnt + 2'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY     = is_march(state) || (state == S_DRAIN);
    DONE     = (state == S_DONE);
    RA       = is_march(state) ? addr : '0;
    WE       = row.wr;
    DW       = '0;
    if (row.wr) DW = row.wr_inv ? ~PAT : PAT;
    cmp_vld  = row.rd;
    cmp_exp  = row.rd_inv ? ~PAT : PAT;
    cmp_elem = elem_of(state);
  end

  assign RB = RA;
  assign RW = RA;

  dffrf_bist_cmp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (start_acc),
    .vld_p0    (cmp_vld),
    .exp_p0    (cmp_exp),
    .addr_p0   (addr),
    .elem_p0   (cmp_elem),
    .DA        (DA),
    .DB        (DB),
    .FAIL      (FAIL),
    .FAIL_ADDR (FAIL_ADDR),
    .FAIL_ELEM (FAIL_ELEM),
    .FAIL_PORT (FAIL_PORT)
  );

endmodule

// File: tb/tb_dffrf_bist.sv
// Bench for dffrf_bist: two instances (combinational and registered RF read) against behavioural RF models.
module tb_dffrf_bist;

  localparam logic [31:0] P = 32'h5555_5555;

  logic        CLK;
  logic        RST_N;
  logic        start0, start1;
  logic        busy0, done0, fail0, we0;
  logic        busy1, done1, fail1, we1;
  logic [4:0]  fail_addr0, ra0, rb0, rw0;
  logic [4:0]  fail_addr1, ra1, rb1, rw1;
  logic [2:0]  fail_elem0, fail_elem1;
  logic [1:0]  fail_port0, fail_port1;
  logic [31:0] da0, db0, dw0, da1, db1, dw1;

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];
  logic [31:0] da1_q, db1_q;
  logic        stuck7, flip12;

  int vectors;
  int miscompares;

  dffrf_bist #(.DATA_W(32), .ADDR_W(5), .RD_LAT(0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .START(start0), .BUSY(busy0), .DONE(done0),
    .FAIL(fail0), .FAIL_ADDR(fail_addr0), .FAIL_ELEM(fail_elem0), .FAIL_PORT(fail_port0),
    .RA(ra0), .RB(rb0), .DA(da0), .DB(db0), .WE(we0), .RW(rw0), .DW(dw0)
  );

  dffrf_bist #(.DATA_W(32), .ADDR_W(5), .RD_LAT(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(start1), .BUSY(busy1), .DONE(done1),
    .FAIL(fail1), .FAIL_ADDR(fail_addr1), .FAIL_ELEM(fail_elem1), .FAIL_PORT(fail_port1),
    .RA(ra1), .RB(rb1), .DA(da1), .DB(db1), .WE(we1), .RW(rw1), .DW(dw1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Combinational-read RF with optional stuck-at-0 on word 7 bit 3 and DB bit-0 flip on word 12
  always @(posedge CLK) begin
    if (we0) mem0[rw0] <= (stuck7 && (rw0 == 5'd7)) ? (dw0 & ~32'h8) : dw0;
  end
  assign da0 = mem0[ra0];
  assign db0 = mem0[rb0] ^ ((flip12 && (rb0 == 5'd12)) ? 32'h1 : 32'h0);

  // Registered-read RF: read returns the pre-edge contents
  always @(posedge CLK) begin
    if (we1) mem1[rw1] <= dw1;
    da1_q <= mem1[ra1];
    db1_q <= mem1[rb1];
  end
  assign da1 = da1_q;
  assign db1 = db1_q;

  task automatic run_march(input int which, input int repulse_at,
                           output int done_edge, output logic busy_e0, output logic we_e0);
    done_edge = -1;
    @(negedge CLK);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge CLK); #1;
    start0 = 1'b0; start1 = 1'b0;
    busy_e0 = (which == 0) ? busy0 : busy1;
    we_e0   = (which == 0) ? we0 : we1;
    for (int e = 1; e <= 400; e++) begin
      if (e == repulse_at) begin
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      @(posedge CLK); #1;
      start0 = 1'b0; start1 = 1'b0;
      if ((which == 0) ? done0 : done1) begin
        done_edge = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; start0 = 1'b0; start1 = 1'b0; stuck7 = 1'b0; flip12 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if ({busy0, done0, fail0, fail_addr0, fail_elem0, fail_port0, ra0, rb0, we0, rw0, dw0} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_dut0: got busy=%b done=%b fail=%b we=%b ra=%0d dw=%h, want all 0",
               busy0, done0, fail0, we0, ra0, dw0);
    end
    vectors++;
    if ({busy1, done1, fail1, fail_addr1, fail_elem1, fail_port1, ra1, rb1, we1, rw1, dw1} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_dut1: got busy=%b done=%b fail=%b we=%b ra=%0d dw=%h, want all 0",
               busy1, done1, fail1, we1, ra1, dw1);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_march_rdlat0();
    int de, bad;
    logic b, w;
    run_march(0, -1, de, b, w);
    vectors++;
    if (b !== 1'b1) begin miscompares++; $display("FAIL lat0_busy_edge0: got %b want 1", b); end
    vectors++;
    if (w !== 1'b1) begin miscompares++; $display("FAIL lat0_we_edge0: got %b want 1", w); end
    vectors++;
    if (de !== 193) begin miscompares++; $display("FAIL lat0_done_edge: got %0d want 193", de); end
    vectors++;
    if (fail0 !== 1'b0) begin miscompares++; $display("FAIL lat0_fail: got %b want 0", fail0); end
    vectors++;
    if ({busy0, we0} !== 2'b00) begin miscompares++; $display("FAIL lat0_idle_after: got busy/we=%b want 00", {busy0, we0}); end
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem0[i] !== P) bad++;
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL lat0_final_mem: got %0d words not 55555555, want 0", bad); end
  endtask

  task automatic test_march_rdlat1();
    int de, bad;
    logic b, w;
    run_march(1, -1, de, b, w);
    vectors++;
    if (b !== 1'b1) begin miscompares++; $display("FAIL lat1_busy_edge0: got %b want 1", b); end
    vectors++;
    if (de !== 194) begin miscompares++; $display("FAIL lat1_done_edge: got %0d want 194", de); end
    vectors++;
    if (fail1 !== 1'b0) begin miscompares++; $display("FAIL lat1_fail: got %b want 0 (addr=%0d elem=%0d)", fail1, fail_addr1, fail_elem1); end
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem1[i] !== P) bad++;
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL lat1_final_mem: got %0d words not 55555555, want 0", bad); end
  endtask

  task automatic test_stuck_bit();
    int de;
    logic b, w;
    stuck7 = 1'b1;
    run_march(0, -1, de, b, w);
    stuck7 = 1'b0;
    vectors++;
    if (de !== 193) begin miscompares++; $display("FAIL stuck_done_edge: got %0d want 193", de); end
    vectors++;
    if (fail0 !== 1'b1) begin miscompares++; $display("FAIL stuck_flag: got %b want 1", fail0); end
    vectors++;
    if (fail_elem0 !== 3'd2) begin miscompares++; $display("FAIL stuck_elem: got %0d want 2", fail_elem0); end
    vectors++;
    if (fail_addr0 !== 5'd7) begin miscompares++; $display("FAIL stuck_addr: got %0d want 7", fail_addr0); end
    vectors++;
    if (fail_port0 !== 2'b11) begin miscompares++; $display("FAIL stuck_port: got %b want 11", fail_port0); end
  endtask

  task automatic test_db_flip();
    int de;
    logic b, w;
    flip12 = 1'b1;
    run_march(0, -1, de, b, w);
    flip12 = 1'b0;
    vectors++;
    if (fail0 !== 1'b1) begin miscompares++; $display("FAIL dbflip_flag: got %b want 1", fail0); end
    vectors++;
    if (fail_port0 !== 2'b10) begin miscompares++; $display("FAIL dbflip_port: got %b want 10", fail_port0); end
    vectors++;
    if (fail_elem0 !== 3'd1) begin miscompares++; $display("FAIL dbflip_elem: got %0d want 1", fail_elem0); end
    vectors++;
    if (fail_addr0 !== 5'd12) begin miscompares++; $display("FAIL dbflip_addr: got %0d want 12", fail_addr0); end
  endtask

  task automatic test_start_ignored();
    int de;
    logic b, w;
    run_march(0, 40, de, b, w);
    vectors++;
    if (de !== 193) begin miscompares++; $display("FAIL repulse_done_edge: got %0d want 193", de); end
    vectors++;
    if (fail0 !== 1'b0) begin miscompares++; $display("FAIL repulse_fail_cleared: got %b want 0", fail0); end
  endtask

  task automatic test_reset_midrun();
    int de, bad;
    logic b, w;
    @(negedge CLK);
    start0 = 1'b1;
    @(posedge CLK); #1;
    start0 = 1'b0;
    repeat (50) @(posedge CLK);
    #1;
    vectors++;
    if ({busy0, we0} !== 2'b11) begin miscompares++; $display("FAIL midrun_busy_before_rst: got busy/we=%b want 11", {busy0, we0}); end
    RST_N = 1'b0;
    #1;
    vectors++;
    if ({busy0, done0, fail0, fail_addr0, fail_elem0, fail_port0, ra0, rb0, we0, rw0, dw0} !== '0) begin
      miscompares++;
      $display("FAIL midrun_async_clear: got busy=%b we=%b ra=%0d dw=%h, want all 0", busy0, we0, ra0, dw0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    run_march(0, -1, de, b, w);
    vectors++;
    if (de !== 193) begin miscompares++; $display("FAIL midrun_rerun_done_edge: got %0d want 193", de); end
    vectors++;
    if (fail0 !== 1'b0) begin miscompares++; $display("FAIL midrun_rerun_fail: got %b want 0", fail0); end
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem0[i] !== P) bad++;
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL midrun_rerun_mem: got %0d words not 55555555, want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int de;
    de = -1;
    @(negedge CLK);
    start0 = 1'b1;
    @(posedge CLK); #1;
    vectors++;
    if ({busy0, done0} !== 2'b10) begin miscompares++; $display("FAIL b2b_restart: got busy/done=%b want 10", {busy0, done0}); end
    start0 = 1'b0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge CLK); #1;
      if (done0) begin de = e; break; end
    end
    vectors++;
    if (de !== 193) begin miscompares++; $display("FAIL b2b_done_edge: got %0d want 193", de); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_march_rdlat0();
    test_march_rdlat1();
    test_stuck_bit();
    test_db_flip();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
